// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer for an external 1-bit ALU slice: shifts operands out LSB first,
// collects the slice result, and provides a start/done handshake with result flags.
module alu_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal_op,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_bnegate,
  output logic             slice_less,
  output logic [1:0]       slice_aluop,
  input  logic             slice_result,
  input  logic             slice_carryout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SLT_FIX = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [2:0] o);
    logic ok;
    case (o)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] aluop_of(input logic [2:0] o);
    logic [1:0] sel;
    case (o)
      OP_AND:  sel = 2'b00;
      OP_OR:   sel = 2'b01;
      default: sel = 2'b10;
    endcase
    return sel;
  endfunction

  function automatic logic bneg_of(input logic [2:0] o);
    logic neg;
    case (o)
      OP_SUB, OP_SLT: neg = 1'b1;
      default:        neg = 1'b0;
    endcase
    return neg;
  endfunction

  state_t           state;
  // Bit 0 of each operand is loaded straight into the slice pins, so only the upper bits are kept here.
  logic [WIDTH-2:0] a_sh;
  logic [WIDTH-2:0] b_sh;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_r;
  logic             sign_r;

  logic [WIDTH-1:0] res_shift;
  logic             last_bit;
  logic             ovf_bit;

  assign slice_less = 1'b0;

  // Next-result and last-bit decode for the RUN state.
  always_comb begin
    res_shift = {slice_result, result[WIDTH-1:1]};
    last_bit  = (cnt == CW'(WIDTH - 1));
    ovf_bit   = slice_cin ^ slice_carryout;
  end

  // Op FSM; slice pins are registered and preloaded one bit ahead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      cnt           <= '0;
      op_r          <= 3'b000;
      sign_r        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      zero          <= 1'b0;
      overflow      <= 1'b0;
      illegal_op    <= 1'b0;
      slice_a       <= 1'b0;
      slice_b       <= 1'b0;
      slice_cin     <= 1'b0;
      slice_bnegate <= 1'b0;
      slice_aluop   <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (op_legal(op)) begin
              a_sh          <= a_in[WIDTH-1:1];
              b_sh          <= b_in[WIDTH-1:1];
              op_r          <= op;
              cnt           <= '0;
              illegal_op    <= 1'b0;
              slice_a       <= a_in[0];
              slice_b       <= b_in[0];
              slice_cin     <= bneg_of(op);
              slice_bnegate <= bneg_of(op);
              slice_aluop   <= aluop_of(op);
              state         <= RUN;
            end else begin
              result     <= '0;
              zero       <= 1'b1;
              overflow   <= 1'b0;
              illegal_op <= 1'b1;
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end
        RUN: begin
          result <= res_shift;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            overflow      <= (slice_aluop == 2'b10) ? ovf_bit : 1'b0;
            sign_r        <= slice_result;
            slice_a       <= 1'b0;
            slice_b       <= 1'b0;
            slice_cin     <= 1'b0;
            slice_bnegate <= 1'b0;
            slice_aluop   <= 2'b00;
            if (op_r == OP_SLT) begin
              state <= SLT_FIX;
            end else begin
              zero  <= (res_shift == '0);
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            slice_a   <= a_sh[0];
            slice_b   <= b_sh[0];
            slice_cin <= slice_carryout;
          end
        end
        SLT_FIX: begin
          result <= {{(WIDTH-1){1'b0}}, sign_r ^ overflow};
          zero   <= ~(sign_r ^ overflow);
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a behavioural 1-bit ALU slice and a
// scoreboard of expected results compared whenever done pulses.
module tb_alu_serial_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, zero, overflow, illegal_op;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_cin, slice_bnegate, slice_less;
  logic [1:0]   slice_aluop;
  logic         slice_result, slice_carryout;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    logic         ill;
    logic [7:0]   lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow),
    .illegal_op(illegal_op), .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_bnegate(slice_bnegate), .slice_less(slice_less), .slice_aluop(slice_aluop),
    .slice_result(slice_result), .slice_carryout(slice_carryout)
  );

  always #5 clk = ~clk;

  // Behavioural model of the external 1-bit ALU slice.
  logic bx;
  assign bx = slice_b ^ slice_bnegate;
  assign slice_result = (slice_aluop == 2'b00) ? (slice_a & bx) :
                        (slice_aluop == 2'b01) ? (slice_a | bx) :
                        (slice_aluop == 2'b10) ? (slice_a ^ bx ^ slice_cin) : slice_less;
  assign slice_carryout = (slice_a & bx) | (slice_a & slice_cin) | (bx & slice_cin);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] d;
    e.ill = 1'b0;
    e.ovf = 1'b0;
    e.lat = 8'(W + 1);
    case (o)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        d = a + b;
        e.res = d;
        e.ovf = (a[W-1] == b[W-1]) && (d[W-1] != a[W-1]);
      end
      3'b110: begin
        d = a - b;
        e.res = d;
        e.ovf = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
      end
      3'b111: begin
        d = a - b;
        e.ovf = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        e.res = W'(d[W-1] ^ e.ovf);
        e.lat = 8'(W + 2);
      end
      default: begin
        e.res = '0;
        e.ill = 1'b1;
        e.lat = 8'd1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Starts at a negedge; poke>0 raises start again in that cycle (must be ignored).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
    exp_t e, g;
    logic c, bneg, bxi;
    logic [1:0] aop;
    bit seen;
    int ndone;
    e = model(o, a, b);
    sb.push_back(e);
    bneg = (o == 3'b110) || (o == 3'b111);
    aop = (o == 3'b000) ? 2'b00 : (o == 3'b001) ? 2'b01 : 2'b10;
    c = bneg;
    seen = 1'b0;
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk);
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      start = (n == poke);
      op    = 3'(n);
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      if (!e.ill && n <= W) begin
        check("slice_a",       slice_a,       a[n-1]);
        check("slice_b",       slice_b,       b[n-1]);
        check("slice_cin",     slice_cin,     c);
        check("slice_bnegate", slice_bnegate, bneg);
        check("slice_aluop",   slice_aluop,   aop);
        check("slice_less",    slice_less,    1'b0);
        bxi = b[n-1] ^ bneg;
        c = (a[n-1] & bxi) | (a[n-1] & c) | (bxi & c);
      end
      if (done) begin
        seen = 1'b1;
        g = sb.pop_front();
        check("latency",    n,          32'(g.lat));
        check("result",     result,     g.res);
        check("zero",       zero,       g.zero);
        check("overflow",   overflow,   g.ovf);
        check("illegal_op", illegal_op, g.ill);
        check("slice_idle", {slice_a, slice_b, slice_cin, slice_bnegate, slice_less, slice_aluop}, 7'd0);
      end
    end
    check("done_seen", seen, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("done_single", done, 1'b0);
    check("busy_after",  busy, 1'b0);
    if (poke > 0) begin
      ndone = 0;
      for (int k = 0; k < W + 4; k++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check("no_extra_done", ndone, 0);
    end
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, result, zero, overflow, illegal_op,
          slice_a, slice_b, slice_cin, slice_bnegate, slice_less, slice_aluop}, 32'd0);
    rst_n = 1'b1;

    run_op(3'b010, 8'h7F, 8'h01, 0);
    run_op(3'b110, 8'h05, 8'h05, 0);
    run_op(3'b110, 8'h00, 8'h01, 0);
    run_op(3'b111, 8'hFD, 8'h02, 0);
    run_op(3'b111, 8'h7F, 8'h80, 0);
    run_op(3'b000, 8'hF0, 8'h3C, 0);
    run_op(3'b001, 8'hF0, 8'h0C, 0);
    run_op(3'b010, 8'h33, 8'h44, 3);
    run_op(3'b010, 8'hC8, 8'h64, W + 1);
    run_op(3'b011, 8'h12, 8'h34, 0);
    run_op(3'b010, 8'h80, 8'h80, 0);
    run_op(3'b111, 8'h80, 8'h01, 0);
    run_op(3'b110, 8'h80, 8'h01, 0);
    run_op(3'b101, 8'hAA, 8'h55, 2);

    // Reset in the middle of RUN aborts the op without a done pulse.
    start = 1'b1; op = 3'b010; a_in = 8'h7F; b_in = 8'h01;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_mid_run", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_run", {busy, done, result, zero, overflow, illegal_op,
          slice_a, slice_b, slice_cin, slice_bnegate, slice_less, slice_aluop}, 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("reset_no_done", ndone, 0);

    run_op(3'b110, 8'h10, 8'h20, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
